// File: rtl/freq_scan.sv
// freq_scan -- four-digit multiplexed seven-segment display scanner.
//
// Purpose:
//   Takes the four decoded digit codes and the range indicator from the
//   frequency meter. It drives one shared segment bus and four one-hot
//   digit enables. The digits are scanned in the order 3,2,1,0, and each
//   digit is held for SCAN_DIV cycles.
//   The inputs are snapshotted at every frame start, so a frame never
//   mixes digits taken from two different counts. When hold is high at a
//   frame start, the old snapshot is kept instead.
//
// Configuration:
//   FREQ_SCAN_LZB_EN  When defined, leading zeros on digits 3..1 are
//                     blanked. Digit 0 is never blanked.
//                     When undefined, the blanking logic is absent.
//
// Parameters:
//   SCAN_DIV   sysclk cycles per digit slot (must be >= 2)
//   ZERO_SEG   segment code that counts as digit "0" for blanking
//   BLANK_SEG  segment code driven for a blanked digit
//
// Ports:
//   sysclk            in   system clock, rising edge
//   rst               in   asynchronous reset, active low
//   seg3..seg0        in   decoded digit codes, most significant first
//   modein            in   range indicator (decimal point of digit 3)
//   hold              in   1 = keep the snapshot at the next frame start
//   dig_sel[3:0]      out  one-hot digit enable, bit n = digit n
//   seg_out[6:0]      out  segment code for the enabled digit
//   dp_out            out  decimal point for the enabled digit
//   frame_o           out  one-cycle pulse while digit 3 is first shown
module freq_scan #(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter logic [6:0]  ZERO_SEG  = 7'h3F,
  parameter logic [6:0]  BLANK_SEG = 7'h00
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic [6:0] seg3,
  input  logic [6:0] seg2,
  input  logic [6:0] seg1,
  input  logic [6:0] seg0,
  input  logic       modein,
  input  logic       hold,
  output logic [3:0] dig_sel,
  output logic [6:0] seg_out,
  output logic       dp_out,
  output logic       frame_o
);

  localparam int unsigned     PC_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(SCAN_DIV - 1);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [1:0]      idx_q, idx_d;
  logic [6:0]      s3_q, s2_q, s1_q, s0_q;
  logic            sm_q;
  logic [3:0]      dig_sel_q, dig_sel_d;
  logic [6:0]      seg_out_q, seg_out_d;
  logic            dp_out_q, dp_out_d;
  logic            frame_q;

  logic            tick;
  logic            frame_start;
  logic            load;
  logic [6:0]      e3, e2, e1, e0;
  logic            em;

  // ---- prescaler and digit index
  assign tick        = (pc_q == PC_LAST);
  assign pc_d        = tick ? '0 : pc_q + 1'b1;
  // The scan order is 3,2,1,0. Decrementing wraps 0 back to 3.
  assign idx_d       = idx_q - 2'd1;
  assign frame_start = tick && (idx_q == 2'd0);
  assign load        = frame_start && !hold;

  // On a loading frame start, the new inputs bypass the snapshot.
  // Digit 3 therefore never shows the stale value.
  assign e3 = load ? seg3   : s3_q;
  assign e2 = load ? seg2   : s2_q;
  assign e1 = load ? seg1   : s1_q;
  assign e0 = load ? seg0   : s0_q;
  assign em = load ? modein : sm_q;

`ifdef FREQ_SCAN_LZB_EN
  logic blank3, blank2, blank1;

  // A digit is a leading zero only when every more significant digit
  // is also a leading zero.
  assign blank3 = (e3 == ZERO_SEG);
  assign blank2 = blank3 && (e2 == ZERO_SEG);
  assign blank1 = blank2 && (e1 == ZERO_SEG);
`endif

  // ---- output selection for the digit about to be shown
  always_comb begin
    seg_out_d = e0;
    case (idx_d)
      2'd3:    seg_out_d = e3;
      2'd2:    seg_out_d = e2;
      2'd1:    seg_out_d = e1;
      default: seg_out_d = e0;
    endcase
`ifdef FREQ_SCAN_LZB_EN
    if (((idx_d == 2'd3) && blank3) ||
        ((idx_d == 2'd2) && blank2) ||
        ((idx_d == 2'd1) && blank1)) begin
      seg_out_d = BLANK_SEG;
    end
`endif
  end

  assign dig_sel_d = 4'b0001 << idx_d;
  assign dp_out_d  = (idx_d == 2'd3) ? em : 1'b0;

  // ---- state registers
  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      pc_q      <= '0;
      idx_q     <= 2'd0;
      s3_q      <= ZERO_SEG;
      s2_q      <= ZERO_SEG;
      s1_q      <= ZERO_SEG;
      s0_q      <= ZERO_SEG;
      sm_q      <= 1'b0;
      dig_sel_q <= 4'b0000;
      seg_out_q <= BLANK_SEG;
      dp_out_q  <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      frame_q <= frame_start;
      if (load) begin
        s3_q <= seg3;
        s2_q <= seg2;
        s1_q <= seg1;
        s0_q <= seg0;
        sm_q <= modein;
      end
      if (tick) begin
        idx_q     <= idx_d;
        dig_sel_q <= dig_sel_d;
        seg_out_q <= seg_out_d;
        dp_out_q  <= dp_out_d;
      end
    end
  end

  assign dig_sel = dig_sel_q;
  assign seg_out = seg_out_q;
  assign dp_out  = dp_out_q;
  assign frame_o = frame_q;

endmodule

// File: tb/tb_freq_scan.sv
// Testbench for freq_scan with SCAN_DIV = 4.
// The expected blanking results follow FREQ_SCAN_LZB_EN.
// The expected display slots are queued when the inputs for a frame are
// driven. They are popped and compared when the DUT shows each digit.
module tb_freq_scan;
  localparam int unsigned SCAN_DIV  = 4;
  localparam logic [6:0]  ZERO_SEG  = 7'h3F;
  localparam logic [6:0]  BLANK_SEG = 7'h00;

  logic       sysclk = 1'b0;
  logic       rst    = 1'b0;
  logic [6:0] seg3 = 7'h06, seg2 = 7'h5B, seg1 = 7'h4F, seg0 = 7'h66;
  logic       modein = 1'b1;
  logic       hold   = 1'b0;
  logic [3:0] dig_sel;
  logic [6:0] seg_out;
  logic       dp_out;
  logic       frame_o;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [3:0] sel;
    logic [6:0] seg;
    logic       dp;
    logic       frm;
  } exp_t;

  typedef struct packed {
    logic [6:0] s3, s2, s1, s0;
    logic       m;
    logic [6:0] e3, e2, e1, e0;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[6];

  freq_scan #(.SCAN_DIV(SCAN_DIV), .ZERO_SEG(ZERO_SEG), .BLANK_SEG(BLANK_SEG)) dut (
    .sysclk (sysclk),
    .rst    (rst),
    .seg3   (seg3),
    .seg2   (seg2),
    .seg1   (seg1),
    .seg0   (seg0),
    .modein (modein),
    .hold   (hold),
    .dig_sel(dig_sel),
    .seg_out(seg_out),
    .dp_out (dp_out),
    .frame_o(frame_o)
  );

  always #5 sysclk = ~sysclk;

  task automatic step();
    @(posedge sysclk);
    @(negedge sysclk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".dig_sel"}, dig_sel, 4'b0000);
    chk({tag, ".seg_out"}, seg_out, BLANK_SEG);
    chk({tag, ".dp_out"},  dp_out,  1'b0);
    chk({tag, ".frame_o"}, frame_o, 1'b0);
  endtask

  // Queue one frame worth of expected slots. Digit 3 carries the frame
  // pulse and the decimal point.
  task automatic push_frame(input logic [6:0] a3, input logic [6:0] a2,
                            input logic [6:0] a1, input logic [6:0] a0, input logic m);
    sb.push_back('{sel: 4'b1000, seg: a3, dp: m,    frm: 1'b1});
    sb.push_back('{sel: 4'b0100, seg: a2, dp: 1'b0, frm: 1'b0});
    sb.push_back('{sel: 4'b0010, seg: a1, dp: 1'b0, frm: 1'b0});
    sb.push_back('{sel: 4'b0001, seg: a0, dp: 1'b0, frm: 1'b0});
  endtask

  // Each slot starts and ends on the negedge just before a tick.
  task automatic slot(input string tag);
    exp_t e;
    step();
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s.queue: got empty, expected an entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".dig_sel"}, dig_sel, e.sel);
      chk({tag, ".seg_out"}, seg_out, e.seg);
      chk({tag, ".dp_out"},  dp_out,  e.dp);
      chk({tag, ".frame_o"}, frame_o, e.frm);
      step();
      chk({tag, ".frame_end"}, frame_o, 1'b0);
      chk({tag, ".held_sel"},  dig_sel, e.sel);
    end
    step();
    step();
  endtask

  task automatic run_frame(input string tag);
    for (int k = 0; k < 4; k++) slot($sformatf("%s.d%0d", tag, 3 - k));
  endtask

  task automatic release_and_wait(input string tag);
    rst = 1'b1;
    chk({tag, ".pre0"}, dig_sel, 4'b0000);
    for (int k = 1; k < 4; k++) begin
      step();
      chk($sformatf("%s.pre%0d", tag, k), dig_sel, 4'b0000);
    end
  endtask

  initial begin
    vecs[0] = '{s3: 7'h06, s2: 7'h5B, s1: 7'h4F, s0: 7'h66, m: 1'b1,
                e3: 7'h06, e2: 7'h5B, e1: 7'h4F, e0: 7'h66};
    vecs[1] = '{s3: 7'h7F, s2: 7'h6D, s1: 7'h3F, s0: 7'h07, m: 1'b0,
                e3: 7'h7F, e2: 7'h6D, e1: 7'h3F, e0: 7'h07};
`ifdef FREQ_SCAN_LZB_EN
    vecs[2] = '{s3: 7'h3F, s2: 7'h3F, s1: 7'h06, s0: 7'h3F, m: 1'b0,
                e3: 7'h00, e2: 7'h00, e1: 7'h06, e0: 7'h3F};
    vecs[3] = '{s3: 7'h3F, s2: 7'h3F, s1: 7'h3F, s0: 7'h3F, m: 1'b1,
                e3: 7'h00, e2: 7'h00, e1: 7'h00, e0: 7'h3F};
    vecs[4] = '{s3: 7'h3F, s2: 7'h06, s1: 7'h3F, s0: 7'h3F, m: 1'b0,
                e3: 7'h00, e2: 7'h06, e1: 7'h3F, e0: 7'h3F};
    vecs[5] = '{s3: 7'h06, s2: 7'h3F, s1: 7'h3F, s0: 7'h3F, m: 1'b1,
                e3: 7'h06, e2: 7'h3F, e1: 7'h3F, e0: 7'h3F};
`else
    vecs[2] = '{s3: 7'h3F, s2: 7'h3F, s1: 7'h06, s0: 7'h3F, m: 1'b0,
                e3: 7'h3F, e2: 7'h3F, e1: 7'h06, e0: 7'h3F};
    vecs[3] = '{s3: 7'h3F, s2: 7'h3F, s1: 7'h3F, s0: 7'h3F, m: 1'b1,
                e3: 7'h3F, e2: 7'h3F, e1: 7'h3F, e0: 7'h3F};
    vecs[4] = '{s3: 7'h3F, s2: 7'h06, s1: 7'h3F, s0: 7'h3F, m: 1'b0,
                e3: 7'h3F, e2: 7'h06, e1: 7'h3F, e0: 7'h3F};
    vecs[5] = '{s3: 7'h06, s2: 7'h3F, s1: 7'h3F, s0: 7'h3F, m: 1'b1,
                e3: 7'h06, e2: 7'h3F, e1: 7'h3F, e0: 7'h3F};
`endif

    // Reset state, then the first frame after release.
    @(negedge sysclk);
    chk_reset("rst_init");
    step();
    chk_reset("rst_hold");
    release_and_wait("boot");
    push_frame(7'h06, 7'h5B, 7'h4F, 7'h66, 1'b1);
    run_frame("boot");

    // Table-driven frames.
    foreach (vecs[i]) begin
      seg3 = vecs[i].s3; seg2 = vecs[i].s2; seg1 = vecs[i].s1; seg0 = vecs[i].s0;
      modein = vecs[i].m;
      push_frame(vecs[i].e3, vecs[i].e2, vecs[i].e1, vecs[i].e0, vecs[i].m);
      run_frame($sformatf("vec%0d", i));
    end

    // A change to seg0 during digit 2 must wait for the next frame.
    seg3 = 7'h06; seg2 = 7'h5B; seg1 = 7'h4F; seg0 = 7'h66; modein = 1'b1;
    push_frame(7'h06, 7'h5B, 7'h4F, 7'h66, 1'b1);
    slot("mid.d3");
    slot("mid.d2");
    seg0 = 7'h6D;
    slot("mid.d1");
    slot("mid.d0");
    push_frame(7'h06, 7'h5B, 7'h4F, 7'h6D, 1'b1);
    run_frame("mid_next");

    // With hold set at the frame start, the old snapshot is kept. After
    // hold is released mid-frame, the next frame shows the new code.
    hold = 1'b1;
    seg3 = 7'h7F;
    push_frame(7'h06, 7'h5B, 7'h4F, 7'h6D, 1'b1);
    slot("hold.d3");
    hold = 1'b0;
    slot("hold.d2");
    hold = 1'b1;
    slot("hold.d1");
    hold = 1'b0;
    slot("hold.d0");
    push_frame(7'h7F, 7'h5B, 7'h4F, 7'h6D, 1'b1);
    run_frame("hold_rel");

    // Asynchronous reset while digit 1 is shown.
    push_frame(7'h7F, 7'h5B, 7'h4F, 7'h6D, 1'b1);
    slot("ar.d3");
    slot("ar.d2");
    step();
    chk("ar.before", dig_sel, 4'b0010);
    #1 rst = 1'b0;
    #1 chk_reset("ar_async");
    sb.delete();
    step();
    chk_reset("ar_held");
    seg3 = 7'h3F; seg2 = 7'h66; seg1 = 7'h07; seg0 = 7'h7F; modein = 1'b0;
    release_and_wait("ar_rel");
`ifdef FREQ_SCAN_LZB_EN
    push_frame(7'h00, 7'h66, 7'h07, 7'h7F, 1'b0);
`else
    push_frame(7'h3F, 7'h66, 7'h07, 7'h7F, 1'b0);
`endif
    run_frame("ar_first");

    chk("sb.empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/freq_scan.md
# freq_scan

Four-digit multiplexed seven-segment display scanner for the frequency meter. Sits directly downstream of the frequency meter top: it consumes the four decoded digit codes (`freqout3..freqout0`) and the range indicator (`modeout`), and drives one shared segment bus plus four digit enables. Inputs are snapshotted once per scan frame so a frame never mixes digits from two counts. Leading zeros are optionally blanked.

## Interface
- `SCAN_DIV`, 50000: sysclk cycles per digit slot; legal ≥ 2.
- `ZERO_SEG`, 7'h3F: segment code treated as digit "0" for blanking.
- `BLANK_SEG`, 7'h00: segment code driven for a blanked digit.

- `sysclk` in 1: system clock; all state on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `seg3`, `seg2`, `seg1`, `seg0` in 7 each: decoded digit codes, MSD→LSD.
- `modein` in 1: range indicator from meter.
- `hold` in 1: 1 = do not refresh snapshot at frame start.
- `dig_sel` out 4: one-hot digit enable, active-high; bit n = digit n.
- `seg_out` out 7: segment code for the enabled digit.
- `dp_out` out 1: decimal point for the enabled digit.
- `frame_o` out 1: one-cycle pulse when a new frame starts (digit 3 enabled).

## Operation
- Prescaler `pc` counts 0..SCAN_DIV-1 and wraps; `tick` = (`pc` == SCAN_DIV-1).
- Digit index `idx` (2 bits) is the digit shown. Scan order is 3,2,1,0,3,…. On `tick`, `idx` steps to the next digit.
- Frame start is a `tick` where the next `idx` is 3.
  - If `hold` = 0, the snapshot registers `s3..s0` and `sm` load `seg3..seg0` and `modein`.
  - If `hold` = 1, the snapshot keeps its old value.
- Output registers update only on `tick`:
  - `dig_sel` = onehot(next `idx`).
  - `seg_out` = the snapshot code for that digit, after blanking.
  - `dp_out` = `sm` when the next `idx` = 3, else 0.
- On a frame-start tick, the outputs use the value being loaded that same cycle. This is a bypass, so digit 3 never shows the stale snapshot.
- `frame_o` = 1 for exactly the cycle after a frame-start tick, i.e. while the outputs first show digit 3. It is 0 otherwise.
- Blanking (only when the feature is compiled in):
  - Digit 3 is blanked if `s3` == ZERO_SEG.
  - Digit 2 is blanked if digit 3 is blanked and `s2` == ZERO_SEG.
  - Digit 1 is blanked if digit 2 is blanked and `s1` == ZERO_SEG.
  - Digit 0 is never blanked.
  - A blanked digit drives BLANK_SEG. `dp_out` is unaffected by blanking.

## Timing
- Reset values:
  - `pc` = 0, `idx` = 0.
  - `s3..s0` = ZERO_SEG, `sm` = 0.
  - `dig_sel` = 4'b0000, `seg_out` = BLANK_SEG, `dp_out` = 0, `frame_o` = 0.
- First `tick` comes SCAN_DIV cycles after `rst` deasserts. Because `idx` = 0 at reset, the next `idx` is 3, so the first tick is a frame start.
- Each digit is held for SCAN_DIV cycles; a full frame is 4·SCAN_DIV cycles.
- Latency from an input change to the display is at most one frame plus one cycle. Input changes mid-frame are invisible until the next frame start.
- `hold` is sampled only on the frame-start tick. Toggling it at any other time has no effect.
- `rst` asserted mid-frame immediately forces all reset values. Scanning restarts as from power-up.
- `dig_sel` is never multi-hot. It is all-zero only between reset and the first tick.

## Configuration
- `FREQ_SCAN_LZB_EN` defined: leading-zero blanking is active as described under Operation.
- `FREQ_SCAN_LZB_EN` undefined: no blanking. `seg_out` always equals the selected snapshot code, and the comparison logic is absent.

## Test plan
All scenarios use SCAN_DIV = 4, ZERO_SEG = 7'h3F, BLANK_SEG = 7'h00.
- Reset release → `dig_sel` = 0000 for 4 cycles. Then `dig_sel` = 1000 with `frame_o` = 1 for one cycle. Then 0100, 0010, 0001 at 4-cycle spacing, then back to 1000.
- `seg3..0` = 06,5B,4F,66 with `modein` = 1 → over one frame, `seg_out` = 06,5B,4F,66. `dp_out` = 1 only while `dig_sel` = 1000.
- `seg0` changed from 66 to 6D during digit 2 → the current frame still shows 66 on digit 0. The next frame shows 6D.
- `hold` = 1 at a frame start with `seg3` changed from 06 to 7F → digit 3 stays 06. Releasing `hold` before the next frame start → 7F is shown.
- With LZB: `seg3..0` = 3F,3F,06,3F → `seg_out` = 00,00,06,3F. With all four = 3F → 00,00,00,3F. Without the macro: 3F,3F,06,3F.
- `rst` pulsed low while `dig_sel` = 0010 → outputs are at reset values asynchronously. The first frame restarts 4 cycles after release.
